// File: rtl/bp_be_pipe_idiv_iter.sv
// Iterative integer divide/remainder pipe for RV64M DIV/DIVU/REM/REMU and W forms.
// Restoring shift-subtract datapath, one quotient bit per cycle.
//
// Ports:
//   clk_i, reset_n_i         clock, asynchronous active-low reset
//   v_i, ready_o             issue handshake (accept = v_i & ready_o & ~flush_i)
//   op_i                     0 DIV, 1 DIVU, 2 REM, 3 REMU, 4 DIVW, 5 DIVUW, 6 REMW, 7 REMUW
//   rs1_i, rs2_i             dividend, divisor
//   rd_addr_i                destination register tag
//   flush_i                  kills any in-flight or pending op
//   v_o, data_o, rd_addr_o   result, held until yumi_i
//   yumi_i                   consumer takes the result
module bp_be_pipe_idiv_iter #(
    parameter int unsigned data_width_p     = 64,
    parameter int unsigned reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        v_i,
    output logic                        ready_o,
    input  logic [2:0]                  op_i,
    input  logic [data_width_p-1:0]     rs1_i,
    input  logic [data_width_p-1:0]     rs2_i,
    input  logic [reg_addr_width_p-1:0] rd_addr_i,
    input  logic                        flush_i,
    output logic                        v_o,
    output logic [data_width_p-1:0]     data_o,
    output logic [reg_addr_width_p-1:0] rd_addr_o,
    input  logic                        yumi_i
);

    localparam int unsigned W = data_width_p;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e state_q, state_d;

    logic                        is_rem_q;
    logic                        is_w_q;
    logic                        neg_q;
    logic [reg_addr_width_p-1:0] rd_addr_q;
    logic [W:0]                  rem_q;
    logic [W-1:0]                quot_q;
    logic [W-1:0]                div_q;
    logic [6:0]                  cnt_q;
    logic [W-1:0]                data_q;

    logic accept;
    logic calc_last;

    function automatic logic [W-1:0] sext_w(input logic [31:0] v);
        return {{(W-32){v[31]}}, v};
    endfunction

    // ------------------------------------------------------------------
    // Operand preparation (evaluated every cycle, used only on accept)
    // ------------------------------------------------------------------
    logic         is_w, is_rem, is_signed;
    logic [W-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, special_res;
    logic         sa, sb, div_zero, overflow, special;

    always_comb begin
        is_w      = op_i[2];
        is_rem    = op_i[1];
        is_signed = ~op_i[0];

        if (is_w) begin
            a_ext = {{(W-32){is_signed & rs1_i[31]}}, rs1_i[31:0]};
            b_ext = {{(W-32){is_signed & rs2_i[31]}}, rs2_i[31:0]};
        end else begin
            a_ext = rs1_i;
            b_ext = rs2_i;
        end

        sa    = is_signed & a_ext[W-1];
        sb    = is_signed & b_ext[W-1];
        // Magnitude of the most-negative value wraps to 2^(W-1), which is correct unsigned.
        a_mag = sa ? (~a_ext + 1'b1) : a_ext;
        b_mag = sb ? (~b_ext + 1'b1) : b_ext;

        min_neg  = is_w ? {{(W-31){1'b1}}, 31'b0} : {1'b1, {(W-1){1'b0}}};
        div_zero = (b_ext == '0);
        overflow = is_signed & (a_ext == min_neg) & (&b_ext);
        special  = div_zero | overflow;

        if (div_zero) begin
            special_res = is_rem ? a_ext : '1;
        end else begin
            special_res = is_rem ? '0 : a_ext;
        end
        if (is_w) begin
            special_res = sext_w(special_res[31:0]);
        end
    end

    // ------------------------------------------------------------------
    // Iteration step and final result formatting
    // ------------------------------------------------------------------
    logic [W+1:0] rem_wide, diff;
    logic         take;
    logic [W:0]   rem_n;
    logic [W-1:0] quot_n, mag, signed_res, final_res;

    always_comb begin
        rem_wide   = {rem_q, quot_q[W-1]};
        diff       = rem_wide - {2'b00, div_q};
        take       = ~diff[W+1];
        rem_n      = take ? diff[W:0] : rem_wide[W:0];
        quot_n     = {quot_q[W-2:0], take};
        mag        = is_rem_q ? rem_n[W-1:0] : quot_n;
        signed_res = neg_q ? (~mag + 1'b1) : mag;
        final_res  = is_w_q ? sext_w(signed_res[31:0]) : signed_res;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = special ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (calc_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (flush_i || yumi_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs and control strobes (state-only for ready_o / v_o)
    always_comb begin
        ready_o   = (state_q == StIdle);
        v_o       = (state_q == StDone);
        accept    = (state_q == StIdle) & v_i & ~flush_i;
        calc_last = (state_q == StCalc) & (cnt_q == 7'd0);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            is_rem_q  <= 1'b0;
            is_w_q    <= 1'b0;
            neg_q     <= 1'b0;
            rd_addr_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            div_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
        end else if (accept) begin
            is_rem_q  <= is_rem;
            is_w_q    <= is_w;
            neg_q     <= is_rem ? sa : (sa ^ sb);
            rd_addr_q <= rd_addr_i;
            rem_q     <= '0;
            // W ops run 32 steps, so their dividend starts in the upper half.
            quot_q    <= is_w ? {a_mag[31:0], {(W-32){1'b0}}} : a_mag;
            div_q     <= b_mag;
            cnt_q     <= is_w ? 7'd31 : 7'd63;
            if (special) begin
                data_q <= special_res;
            end
        end else if (state_q == StCalc) begin
            rem_q  <= rem_n;
            quot_q <= quot_n;
            if (calc_last) begin
                data_q <= final_res;
            end else begin
                cnt_q <= cnt_q - 7'd1;
            end
        end
    end

    assign data_o    = data_q;
    assign rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_bp_be_pipe_idiv_iter.sv
module tb_bp_be_pipe_idiv_iter;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic        ready_o;
    logic [2:0]  op_i;
    logic [63:0] rs1_i;
    logic [63:0] rs2_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        v_o;
    logic [63:0] data_o;
    logic [4:0]  rd_addr_o;
    logic        yumi_i;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] DIV = 3'd0, DIVU = 3'd1, REM = 3'd2, REMU = 3'd3;
    localparam logic [2:0] DIVW = 3'd4, DIVUW = 3'd5, REMW = 3'd6, REMUW = 3'd7;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] exp;
    } vec_t;

    bp_be_pipe_idiv_iter #(
        .data_width_p    (64),
        .reg_addr_width_p(5)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_addr_i(rd_addr_i),
        .flush_i  (flush_i),
        .v_o      (v_o),
        .data_o   (data_o),
        .rd_addr_o(rd_addr_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    // Called 1 time unit after a rising edge with the unit idle; returns likewise after accept.
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd);
        v_i       = 1'b1;
        op_i      = op;
        rs1_i     = a;
        rs2_i     = b;
        rd_addr_i = rd;
        @(posedge clk_i);
        #1;
        v_i = 1'b0;
    endtask

    // Counts rising edges after the accept edge until v_o is seen (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (v_o !== 1'b1 && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    task automatic take();
        yumi_i = 1'b1;
        @(posedge clk_i);
        #1;
        yumi_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0 || data_o !== 64'd0 || rd_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL reset: ready=%b v=%b data=%h rd=%0d, want 1 0 0 0",
                     ready_o, v_o, data_o, rd_addr_o);
        end
        #10 reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_divrem();
        vec_t vs[6];
        int   lat;
        vs = '{
            '{DIVU, 64'd100, 64'd7, 5'd5, 64'd14},
            '{REMU, 64'd100, 64'd7, 5'd5, 64'd2},
            '{DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFD},
            '{REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF},
            '{REM,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd3, 64'd1},
            '{DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd9, 64'h5555_5555_5555_5555}
        };
        foreach (vs[i]) begin
            issue(vs[i].op, vs[i].a, vs[i].b, vs[i].rd);
            wait_valid(lat);
            checks++;
            if (lat != 64) begin
                errors++;
                $display("FAIL divrem[%0d] latency: got %0d want 64", i, lat);
            end
            checks++;
            if (data_o !== vs[i].exp || rd_addr_o !== vs[i].rd) begin
                errors++;
                $display("FAIL divrem[%0d] result: data=%h rd=%0d want %h %0d",
                         i, data_o, rd_addr_o, vs[i].exp, vs[i].rd);
            end
            take();
            checks++;
            if (v_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL divrem[%0d] release: v=%b ready=%b want 0 1", i, v_o, ready_o);
            end
        end
    endtask

    task automatic test_special();
        vec_t vs[6];
        int   lat;
        vs = '{
            '{DIV,  64'd42, 64'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF},
            '{REMU, 64'd5, 64'd0, 5'd6, 64'd5},
            '{REMW, 64'h1_0000_0005, 64'd0, 5'd7, 64'd5},
            '{DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
                    64'h8000_0000_0000_0000},
            '{REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'd0},
            '{DIVW, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'hFFFF_FFFF_8000_0000}
        };
        foreach (vs[i]) begin
            issue(vs[i].op, vs[i].a, vs[i].b, vs[i].rd);
            wait_valid(lat);
            checks++;
            if (lat != 0) begin
                errors++;
                $display("FAIL special[%0d] latency: got %0d want 0", i, lat);
            end
            checks++;
            if (data_o !== vs[i].exp || rd_addr_o !== vs[i].rd) begin
                errors++;
                $display("FAIL special[%0d] result: data=%h rd=%0d want %h %0d",
                         i, data_o, rd_addr_o, vs[i].exp, vs[i].rd);
            end
            take();
        end
    endtask

    task automatic test_word();
        vec_t vs[4];
        int   lat;
        vs = '{
            '{DIVW,  64'h0000_0001_FFFF_FFF9, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFD},
            '{DIVUW, 64'hFFFF_FFFF, 64'd1, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF},
            '{REMUW, 64'h1_0000_0007, 64'd3, 5'd15, 64'd1},
            '{REMW,  64'hFFFF_FFF9, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF}
        };
        foreach (vs[i]) begin
            issue(vs[i].op, vs[i].a, vs[i].b, vs[i].rd);
            wait_valid(lat);
            checks++;
            if (lat != 32) begin
                errors++;
                $display("FAIL word[%0d] latency: got %0d want 32", i, lat);
            end
            checks++;
            if (data_o !== vs[i].exp || rd_addr_o !== vs[i].rd) begin
                errors++;
                $display("FAIL word[%0d] result: data=%h rd=%0d want %h %0d",
                         i, data_o, rd_addr_o, vs[i].exp, vs[i].rd);
            end
            take();
        end
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        issue(DIVU, 64'd100, 64'd7, 5'd5);
        repeat (9) begin
            @(posedge clk_i);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc: ready=%b v=%b want 1 0", ready_o, v_o);
        end
        seen = 0;
        repeat (80) begin
            @(posedge clk_i);
            #1;
            if (v_o === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_no_valid: v_o high %0d cycles, want 0", seen);
        end
        // Flush in IDLE blocks accept.
        v_i     = 1'b1;
        op_i    = DIVU;
        rs1_i   = 64'd1;
        rs2_i   = 64'd1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        v_i     = 1'b0;
        flush_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: ready=%b want 1", ready_o);
        end
        issue(DIVU, 64'd1000, 64'd10, 5'd17);
        wait_valid(lat);
        checks++;
        if (lat != 64 || data_o !== 64'd100 || rd_addr_o !== 5'd17) begin
            errors++;
            $display("FAIL flush_next: lat=%0d data=%h rd=%0d want 64 %h 17",
                     lat, data_o, rd_addr_o, 64'd100);
        end
        take();
        // Flush together with yumi in DONE.
        issue(DIV, 64'd42, 64'd0, 5'd18);
        flush_i = 1'b1;
        yumi_i  = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        yumi_i  = 1'b0;
        checks++;
        if (v_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: v=%b ready=%b want 0 1", v_o, ready_o);
        end
    endtask

    task automatic test_hold_yumi();
        int lat;
        issue(REMU, 64'd100, 64'd7, 5'd12);
        wait_valid(lat);
        v_i       = 1'b1;
        op_i      = DIVU;
        rs1_i     = 64'd9;
        rs2_i     = 64'd3;
        rd_addr_i = 5'd1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if (v_o !== 1'b1 || ready_o !== 1'b0 || data_o !== 64'd2 || rd_addr_o !== 5'd12) begin
                errors++;
                $display("FAIL hold[%0d]: v=%b ready=%b data=%h rd=%0d want 1 0 2 12",
                         k, v_o, ready_o, data_o, rd_addr_o);
            end
        end
        v_i = 1'b0;
        take();
        @(posedge clk_i);
        #1;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: ready=%b v=%b want 1 0", ready_o, v_o);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        issue(DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd19);
        repeat (10) begin
            @(posedge clk_i);
            #1;
        end
        reset_n_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0 || data_o !== 64'd0 || rd_addr_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b v=%b data=%h rd=%0d want 1 0 0 0",
                     ready_o, v_o, data_o, rd_addr_o);
        end
        #10 reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        issue(DIVU, 64'd100, 64'd7, 5'd5);
        wait_valid(lat);
        checks++;
        if (lat != 64 || data_o !== 64'd14) begin
            errors++;
            $display("FAIL reset_resume: lat=%0d data=%h want 64 %h", lat, data_o, 64'd14);
        end
        take();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd20);
        wait_valid(lat);
        checks++;
        if (lat != 64 || data_o !== 64'hFFFF_FFFF_FFFF_FFF2 || rd_addr_o !== 5'd20) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d data=%h rd=%0d want 64 fffffffffffffff2 20",
                     lat, data_o, rd_addr_o);
        end
        take();
        issue(REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd21);
        wait_valid(lat);
        checks++;
        if (lat != 64 || data_o !== 64'hFFFF_FFFF_FFFF_FFFE || rd_addr_o !== 5'd21) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d data=%h rd=%0d want 64 fffffffffffffffe 21",
                     lat, data_o, rd_addr_o);
        end
        take();
    endtask

    initial begin
        reset_n_i = 1'b0;
        v_i       = 1'b0;
        op_i      = 3'd0;
        rs1_i     = 64'd0;
        rs2_i     = 64'd0;
        rd_addr_i = 5'd0;
        flush_i   = 1'b0;
        yumi_i    = 1'b0;
        test_reset();
        test_divrem();
        test_special();
        test_word();
        test_flush();
        test_hold_yumi();
        test_reset_mid_calc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
